// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if
//   Bundles the ID -> EX operand-stage traffic: the incoming decoded
//   instruction, the EX/MEM and MEM/WB forwarding taps, the flush request
//   and the registered operand bundle sent toward the ALU.
//   master : the surroundings (ID, forwarding sources, ALU side)
//   slave  : the operand stage itself
interface ex_operand_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rs_addr;
    logic [REG_AW-1:0] in_rt_addr;
    logic [DATA_W-1:0] in_rs_data;
    logic [DATA_W-1:0] in_rt_data;
    logic [15:0]       in_imm;
    logic [4:0]        in_shamt;
    logic [3:0]        in_aluc;
    logic              in_a_sel;
    logic [1:0]        in_b_sel;
    logic [REG_AW-1:0] in_dest;
    logic              in_wen;
    logic              fwd_mem_wen;
    logic [REG_AW-1:0] fwd_mem_addr;
    logic [DATA_W-1:0] fwd_mem_data;
    logic              fwd_wb_wen;
    logic [REG_AW-1:0] fwd_wb_addr;
    logic [DATA_W-1:0] fwd_wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [3:0]        out_aluc;
    logic [DATA_W-1:0] out_store_data;
    logic [REG_AW-1:0] out_dest;
    logic              out_wen;

    modport master (
        output flush, in_valid, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data,
               in_imm, in_shamt, in_aluc, in_a_sel, in_b_sel, in_dest, in_wen,
               fwd_mem_wen, fwd_mem_addr, fwd_mem_data,
               fwd_wb_wen, fwd_wb_addr, fwd_wb_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_aluc, out_store_data,
               out_dest, out_wen
    );

    modport slave (
        input  flush, in_valid, in_rs_addr, in_rt_addr, in_rs_data, in_rt_data,
               in_imm, in_shamt, in_aluc, in_a_sel, in_b_sel, in_dest, in_wen,
               fwd_mem_wen, fwd_mem_addr, fwd_mem_data,
               fwd_wb_wen, fwd_wb_addr, fwd_wb_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_aluc, out_store_data,
               out_dest, out_wen
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   ID/EX register stage in front of the 32-bit ALU. Resolves RAW hazards
//   by forwarding from EX/MEM (highest priority) and MEM/WB, selects ALU
//   operands A and B, and registers them together with the ALU opcode,
//   store data and write-back tags behind a valid/ready handshake.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset, clears every output register
//     bus  : ex_operand_stage_if.slave (ID inputs, forwarding taps, flush,
//            registered ALU-side outputs)
module ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                rst,
    ex_operand_stage_if.slave   bus
);

    // Forwarding mux for one source index. Register 0 is hard-wired and is
    // never forwarded, even if a younger stage claims to write it.
    function automatic logic [DATA_W-1:0] fwd_pick(
        input logic [REG_AW-1:0] idx,
        input logic [DATA_W-1:0] rf_data,
        input logic              mem_wen,
        input logic [REG_AW-1:0] mem_addr,
        input logic [DATA_W-1:0] mem_data,
        input logic              wb_wen,
        input logic [REG_AW-1:0] wb_addr,
        input logic [DATA_W-1:0] wb_data
    );
        logic [DATA_W-1:0] r;
        r = rf_data;
        if (idx != '0) begin
            if (mem_wen && (mem_addr == idx))
                r = mem_data;
            else if (wb_wen && (wb_addr == idx))
                r = wb_data;
        end
        return r;
    endfunction

    function automatic logic signed [DATA_W-1:0] sext_imm(input logic signed [15:0] imm);
        return {{(DATA_W-16){imm[15]}}, imm};
    endfunction

    function automatic logic [DATA_W-1:0] zext_imm(input logic [15:0] imm);
        return {{(DATA_W-16){1'b0}}, imm};
    endfunction

    function automatic logic [DATA_W-1:0] zext_shamt(input logic [4:0] shamt);
        return {{(DATA_W-5){1'b0}}, shamt};
    endfunction

    logic [DATA_W-1:0] rs_fwd_p0;
    logic [DATA_W-1:0] rt_fwd_p0;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;

    logic              vld_p1;
    logic              wen_p1;
    logic [DATA_W-1:0] a_p1;
    logic [DATA_W-1:0] b_p1;
    logic [3:0]        aluc_p1;
    logic [DATA_W-1:0] store_p1;
    logic [REG_AW-1:0] dest_p1;

    logic              in_ready;

    // ---- p0: forwarding and operand selection (combinational) ----
    always_comb begin
        rs_fwd_p0 = fwd_pick(bus.in_rs_addr, bus.in_rs_data,
                             bus.fwd_mem_wen, bus.fwd_mem_addr, bus.fwd_mem_data,
                             bus.fwd_wb_wen, bus.fwd_wb_addr, bus.fwd_wb_data);
        rt_fwd_p0 = fwd_pick(bus.in_rt_addr, bus.in_rt_data,
                             bus.fwd_mem_wen, bus.fwd_mem_addr, bus.fwd_mem_data,
                             bus.fwd_wb_wen, bus.fwd_wb_addr, bus.fwd_wb_data);

        // Shift-by-immediate ops take the count from shamt on operand A.
        a_p0 = bus.in_a_sel ? zext_shamt(bus.in_shamt) : rs_fwd_p0;

        b_p0 = '0;
        unique case (bus.in_b_sel)
            2'b00:   b_p0 = rt_fwd_p0;
            2'b01:   b_p0 = sext_imm(bus.in_imm);
            2'b10:   b_p0 = zext_imm(bus.in_imm);
            default: b_p0 = '0;
        endcase
    end

    // A free output slot, or one being emptied this cycle, can take a new
    // instruction; flush deliberately does not gate this.
    assign in_ready = !vld_p1 || bus.out_ready;

    // ---- p1: registered operand bundle toward the ALU ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            wen_p1   <= 1'b0;
            a_p1     <= '0;
            b_p1     <= '0;
            aluc_p1  <= '0;
            store_p1 <= '0;
            dest_p1  <= '0;
        end else if (bus.flush) begin
            // Squash both the held and any offered instruction; data is
            // left stale since nothing qualifies it without out_valid.
            vld_p1 <= 1'b0;
            wen_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= bus.in_valid;
            wen_p1 <= bus.in_valid && bus.in_wen;
            if (bus.in_valid) begin
                a_p1     <= a_p0;
                b_p1     <= b_p0;
                aluc_p1  <= bus.in_aluc;
                store_p1 <= rt_fwd_p0;
                dest_p1  <= bus.in_dest;
            end
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = vld_p1;
    assign bus.out_wen        = wen_p1;
    assign bus.out_a          = a_p1;
    assign bus.out_b          = b_p1;
    assign bus.out_aluc       = aluc_p1;
    assign bus.out_store_data = store_p1;
    assign bus.out_dest       = dest_p1;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage
//   Randomized and directed stimulus for ex_operand_stage, checked against
//   a transaction-level model of the stage's output slot.
module tb_ex_operand_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic clk;
    logic rst;

    ex_operand_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    ex_operand_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model of what should sit in the output slot.
    typedef struct {
        logic        valid;
        logic        wen;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  aluc;
        logic [31:0] store;
        logic [4:0]  dest;
        logic        known;  // data fields have a defined expected value
    } slot_t;

    slot_t m;

    function automatic logic [31:0] m_fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return rf;
        if (bus.fwd_mem_wen && bus.fwd_mem_addr == idx) return bus.fwd_mem_data;
        if (bus.fwd_wb_wen && bus.fwd_wb_addr == idx) return bus.fwd_wb_data;
        return rf;
    endfunction

    // One clock: check in_ready, advance the model from the inputs, check outputs.
    task automatic step();
        logic        exp_ready;
        logic [31:0] rs_v, rt_v, a_v, b_v;
        #1;
        exp_ready = !m.valid || bus.out_ready;
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_ready});
        rs_v = m_fwd(bus.in_rs_addr, bus.in_rs_data);
        rt_v = m_fwd(bus.in_rt_addr, bus.in_rt_data);
        a_v  = bus.in_a_sel ? 32'(bus.in_shamt) : rs_v;
        case (bus.in_b_sel)
            2'd0: b_v = rt_v;
            2'd1: b_v = 32'($signed(bus.in_imm));
            2'd2: b_v = 32'(bus.in_imm);
            default: b_v = 32'd0;
        endcase
        @(posedge clk);
        if (rst) begin
            m = '{valid: 1'b0, wen: 1'b0, a: 0, b: 0, aluc: 0, store: 0, dest: 0, known: 1'b1};
        end else if (bus.flush) begin
            m.valid = 1'b0; m.wen = 1'b0; m.known = 1'b0;
        end else if (exp_ready) begin
            if (bus.in_valid) begin
                m = '{valid: 1'b1, wen: bus.in_wen, a: a_v, b: b_v, aluc: bus.in_aluc,
                      store: rt_v, dest: bus.in_dest, known: 1'b1};
            end else begin
                m.valid = 1'b0; m.wen = 1'b0; m.known = 1'b0;
            end
        end
        #1;
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m.valid});
        chk("out_wen", {31'b0, bus.out_wen}, {31'b0, m.wen});
        if (m.valid || m.known) begin
            chk("out_a", bus.out_a, m.a);
            chk("out_b", bus.out_b, m.b);
            chk("out_aluc", {28'b0, bus.out_aluc}, {28'b0, m.aluc});
            chk("out_store", bus.out_store_data, m.store);
            chk("out_dest", {27'b0, bus.out_dest}, {27'b0, m.dest});
        end
    endtask

    task automatic idle_inputs();
        bus.flush = 0; bus.in_valid = 0; bus.in_rs_addr = 0; bus.in_rt_addr = 0;
        bus.in_rs_data = 0; bus.in_rt_data = 0; bus.in_imm = 0; bus.in_shamt = 0;
        bus.in_aluc = 0; bus.in_a_sel = 0; bus.in_b_sel = 0; bus.in_dest = 0;
        bus.in_wen = 0; bus.fwd_mem_wen = 0; bus.fwd_mem_addr = 0; bus.fwd_mem_data = 0;
        bus.fwd_wb_wen = 0; bus.fwd_wb_addr = 0; bus.fwd_wb_data = 0; bus.out_ready = 1;
    endtask

    task automatic rand_inputs();
        bus.in_valid     = ($urandom_range(0, 3) != 0);
        bus.out_ready    = ($urandom_range(0, 3) != 0);
        bus.flush        = ($urandom_range(0, 15) == 0);
        bus.in_rs_addr   = 5'($urandom_range(0, 3));
        bus.in_rt_addr   = 5'($urandom_range(0, 3));
        bus.in_rs_data   = $urandom;
        bus.in_rt_data   = $urandom;
        bus.in_imm       = 16'($urandom);
        bus.in_shamt     = 5'($urandom);
        bus.in_aluc      = 4'($urandom);
        bus.in_a_sel     = 1'($urandom);
        bus.in_b_sel     = 2'($urandom);
        bus.in_dest      = 5'($urandom);
        bus.in_wen       = 1'($urandom);
        bus.fwd_mem_wen  = 1'($urandom);
        bus.fwd_mem_addr = 5'($urandom_range(0, 3));
        bus.fwd_mem_data = $urandom;
        bus.fwd_wb_wen   = 1'($urandom);
        bus.fwd_wb_addr  = 5'($urandom_range(0, 3));
        bus.fwd_wb_data  = $urandom;
        rst              = ($urandom_range(0, 63) == 0);
    endtask

    initial begin
        m = '{valid: 1'b0, wen: 1'b0, a: 0, b: 0, aluc: 0, store: 0, dest: 0, known: 1'b0};
        idle_inputs();

        // Reset with an instruction offered: nothing gets in.
        rst = 1; bus.in_valid = 1; bus.in_wen = 1; bus.in_dest = 5'd9;
        step(); step();
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_wen", {31'b0, bus.out_wen}, 32'd0);
        chk("rst_a", bus.out_a, 32'd0);
        chk("rst_dest", {27'b0, bus.out_dest}, 32'd0);
        chk("rst_ready", {31'b0, bus.in_ready}, 32'd1);
        rst = 0;
        step();
        chk("first_valid", {31'b0, bus.out_valid}, 32'd1);

        // Operand select.
        bus.in_rs_data = 32'h5; bus.in_rt_data = 32'h8000_0000; bus.in_shamt = 5'd4;
        bus.in_rs_addr = 5'd1; bus.in_rt_addr = 5'd2;
        bus.in_a_sel = 1; bus.in_b_sel = 2'b00; bus.in_aluc = 4'b1010;
        step();
        chk("opsel_a", bus.out_a, 32'h4);
        chk("opsel_b_rt", bus.out_b, 32'h8000_0000);
        chk("opsel_aluc", {28'b0, bus.out_aluc}, 32'hA);
        bus.in_imm = 16'hFFFE; bus.in_b_sel = 2'b01;
        step();
        chk("opsel_b_sext", bus.out_b, 32'hFFFF_FFFE);
        chk("opsel_store", bus.out_store_data, 32'h8000_0000);
        bus.in_b_sel = 2'b10;
        step();
        chk("opsel_b_zext", bus.out_b, 32'h0000_FFFE);

        // Forward priority.
        bus.in_a_sel = 0; bus.in_rs_addr = 5'd3; bus.in_rs_data = 32'h11;
        bus.fwd_mem_wen = 1; bus.fwd_mem_addr = 5'd3; bus.fwd_mem_data = 32'h22;
        bus.fwd_wb_wen = 1; bus.fwd_wb_addr = 5'd3; bus.fwd_wb_data = 32'h33;
        step();
        chk("fwd_mem", bus.out_a, 32'h22);
        bus.fwd_mem_wen = 0;
        step();
        chk("fwd_wb", bus.out_a, 32'h33);

        // Register zero is never forwarded.
        bus.in_rs_addr = 0; bus.in_rs_data = 0;
        bus.fwd_mem_wen = 1; bus.fwd_mem_addr = 0; bus.fwd_mem_data = 32'hDEAD;
        bus.fwd_wb_addr = 0;
        step();
        chk("fwd_r0", bus.out_a, 32'h0);
        bus.fwd_mem_wen = 0; bus.fwd_wb_wen = 0;

        // Backpressure: three instructions tagged by dest.
        bus.in_a_sel = 1; bus.in_b_sel = 2'b11; bus.out_ready = 1;
        bus.in_dest = 5'd11; bus.in_shamt = 5'd1;
        step();
        chk("bp_i1", {27'b0, bus.out_dest}, 32'd11);
        bus.out_ready = 0; bus.in_dest = 5'd12; bus.in_shamt = 5'd2;
        step(); step();
        chk("bp_hold_dest", {27'b0, bus.out_dest}, 32'd11);
        chk("bp_hold_a", bus.out_a, 32'd1);
        chk("bp_ready_low", {31'b0, bus.in_ready}, 32'd0);
        bus.out_ready = 1;
        step();
        chk("bp_i2", {27'b0, bus.out_dest}, 32'd12);
        bus.in_dest = 5'd13; bus.in_shamt = 5'd3;
        step();
        chk("bp_i3", {27'b0, bus.out_dest}, 32'd13);
        chk("bp_i3_valid", {31'b0, bus.out_valid}, 32'd1);

        // Flush during a stall with a new instruction offered.
        bus.out_ready = 0; bus.flush = 1; bus.in_dest = 5'd20; bus.in_wen = 1;
        step();
        chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("flush_wen", {31'b0, bus.out_wen}, 32'd0);
        bus.flush = 0; bus.in_valid = 0;
        step();
        chk("flush_dropped", {31'b0, bus.out_valid}, 32'd0);

        // Reset during a stall loses the held instruction.
        bus.in_valid = 1; bus.out_ready = 1;
        step();
        bus.out_ready = 0; rst = 1;
        step();
        rst = 0; bus.in_valid = 0;
        step();
        chk("rst_stall_valid", {31'b0, bus.out_valid}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
